// File: rtl/muldiv_if.sv
// Request/response bundle between the core and the iterative RV32M multiply/divide unit.
interface muldiv_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) ();
  logic                     start;
  logic [2:0]               op;
  logic [DATA_WIDTH-1:0]    rs1_val;
  logic [DATA_WIDTH-1:0]    rs2_val;
  logic [ADDRESS_WIDTH-1:0] rd_in;
  logic                     busy;
  logic                     done;
  logic [DATA_WIDTH-1:0]    result;
  logic [ADDRESS_WIDTH-1:0] rd_out;
  logic                     wb_en;

  modport master (
    output start, op, rs1_val, rs2_val, rd_in,
    input  busy, done, result, rd_out, wb_en
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, rd_in,
    output busy, done, result, rd_out, wb_en
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration phase.
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t                   state, state_next;
  logic [CW-1:0]            cnt;
  logic [2:0]               op_p0;
  logic [ADDRESS_WIDTH-1:0] rd_p0;
  logic [W-1:0]             opnd_p0;
  logic [2*W-1:0]           acc_p0;
  logic                     neg_p0;
  logic                     special_p0;
  logic [W-1:0]             special_val_p0;
  logic [W-1:0]             result_q;
  logic [ADDRESS_WIDTH-1:0] rd_out_q;

  function automatic logic [W-1:0] cond_neg_w(input logic [W-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*W-1:0] cond_neg_2w(input logic [2*W-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  logic         a_signed, b_signed, a_neg, b_neg, is_div, is_rem, div_zero, div_ovf;
  logic [W-1:0] a_mag, b_mag, spec_val;

  always_comb begin
    a_signed = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b100) || (bus.op == 3'b110);
    b_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    a_neg    = a_signed & bus.rs1_val[W-1];
    b_neg    = b_signed & bus.rs2_val[W-1];
    a_mag    = cond_neg_w(bus.rs1_val, a_neg);
    b_mag    = cond_neg_w(bus.rs2_val, b_neg);
    is_div   = bus.op[2];
    is_rem   = bus.op[2] & bus.op[1];
    div_zero = is_div && (bus.rs2_val == '0);
    div_ovf  = is_div && !bus.op[0] && (bus.rs1_val == MIN_NEG) && (bus.rs2_val == '1);
    if (div_zero) spec_val = bus.op[1] ? bus.rs1_val : '1;
    else          spec_val = bus.op[1] ? '0 : MIN_NEG;
  end

  // Iteration step: multiply adds the multiplicand into the high half and shifts right;
  // divide shifts the partial remainder left and restores when the trial subtract underflows.
  logic [W:0]     mul_sum, div_shift;
  logic [W-1:0]   div_diff, rem_next;
  logic           div_ge;
  logic [2*W-1:0] step;

  always_comb begin
    mul_sum   = {1'b0, acc_p0[2*W-1:W]} + {1'b0, opnd_p0 & {W{acc_p0[0]}}};
    div_shift = {acc_p0[2*W-1:W], acc_p0[W-1]};
    div_ge    = div_shift >= {1'b0, opnd_p0};
    div_diff  = div_shift[W-1:0] - opnd_p0;
    rem_next  = div_ge ? div_diff : div_shift[W-1:0];
    step      = op_p0[2] ? {rem_next, acc_p0[W-2:0], div_ge} : {mul_sum, acc_p0[W-1:1]};
  end

  logic [2*W-1:0] prod;
  logic [W-1:0]   fin_val;

  always_comb begin
    prod = cond_neg_2w(acc_p0, neg_p0);
    case (op_p0)
      3'b000:         fin_val = prod[W-1:0];
      3'b100, 3'b101: fin_val = cond_neg_w(acc_p0[W-1:0], neg_p0);
      3'b110, 3'b111: fin_val = cond_neg_w(acc_p0[2*W-1:W], neg_p0);
      default:        fin_val = prod[2*W-1:W];
    endcase
    if (special_p0) fin_val = special_val_p0;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = CALC;
      CALC: begin
`ifdef MULDIV_EARLY_OUT_EN
        if (special_p0 || cnt == CW'(W-1)) state_next = FIN;
`else
        if (cnt == CW'(W-1)) state_next = FIN;
`endif
      end
      FIN:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state <= state_next;
      if (state == CALC) cnt <= cnt + 1'b1;
      else               cnt <= '0;
      if (state == FIN) begin
        result_q <= fin_val;
        rd_out_q <= rd_p0;
      end
    end
  end

  // Acceptance stage: operands reduced to magnitudes, result sign and forced value captured.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      op_p0          <= bus.op;
      rd_p0          <= bus.rd_in;
      opnd_p0        <= is_div ? b_mag : a_mag;
      acc_p0         <= {{W{1'b0}}, (is_div ? a_mag : b_mag)};
      neg_p0         <= is_rem ? a_neg : (a_neg ^ b_neg);
      special_p0     <= div_zero | div_ovf;
      special_val_p0 <= spec_val;
    end else if (state == CALC) begin
      acc_p0 <= step;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.wb_en  = (state == DONE) && (rd_out_q != '0);
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();
  muldiv_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Reference model: timeline of one accepted request, updated on every rising edge.
  bit          m_busy = 1'b0;
  logic [31:0] m_res  = '0;
  logic [4:0]  m_rd   = '0;
  logic [31:0] p_res;
  logic [4:0]  p_rd;
  int          done_at = -1;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy  = 1'b0;
      m_res   = '0;
      m_rd    = '0;
      done_at = -1;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy  = 1'b1;
        p_res   = ref_op(bus.op, bus.rs1_val, bus.rs2_val);
        p_rd    = bus.rd_in;
        done_at = cyc + ((EARLY && is_special(bus.op, bus.rs1_val, bus.rs2_val)) ? 2 : 33);
      end
    end else if (cyc == done_at) begin
      m_res = p_res;
      m_rd  = p_rd;
    end else if (cyc == done_at + 1) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    bit exp_done;
    if (cyc >= 1) begin
      exp_done = m_busy && (cyc == done_at);
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("done", 32'(bus.done), 32'(exp_done));
      check("wb_en", 32'(bus.wb_en), 32'(exp_done && (m_rd != 0)));
      check("result", bus.result, m_res);
      check("rd_out", 32'(bus.rd_out), 32'(m_rd));
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit chk_lit, input logic [31:0] lit,
                       input int extra_at);
    int c0;
    int lat;
    bit got;
    for (int i = 0; i < 50 && bus.busy; i++) @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    @(negedge clk);
    c0          = cyc;
    bus.start   = 1'b0;
    bus.op      = 3'($urandom);
    bus.rs1_val = $urandom;
    bus.rs2_val = $urandom;
    bus.rd_in   = 5'($urandom);
    lat = (EARLY && is_special(op, a, b)) ? 2 : 33;
    got = 1'b0;
    for (int i = 0; i < 45; i++) begin
      bus.start = (extra_at != 0) && (cyc == c0 + extra_at - 1);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      check("latency", 32'(cyc - c0), 32'(lat));
      if (chk_lit) check("result_lit", bus.result, lit);
      check("rd_out_lit", 32'(bus.rd_out), 32'(rd));
      check("wb_en_lit", 32'(bus.wb_en), 32'(rd != 0));
    end else begin
      check("done_timeout", 32'd0, 32'd1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    if (got) check("busy_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int c0;
    bit seen;
    bus.start   = 1'b0;
    bus.op      = '0;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_in   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wb_en", 32'(bus.wb_en), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rd_out", 32'(bus.rd_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 32'hFFFF_FFEB, 0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b1, 32'h4000_0000, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 32'hFFFF_FFFE, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 1'b1, 32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, 32'hFFFF_FFFD, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, 32'hFFFF_FFFF, 0);
    do_op(3'd5, 32'd5, 32'd0, 5'd7, 1'b1, 32'hFFFF_FFFF, 0);
    do_op(3'd7, 32'd5, 32'd0, 5'd8, 1'b1, 32'd5, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1, 32'h8000_0000, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'd0, 0);
    do_op(3'd0, 32'd3, 32'd9, 5'd11, 1'b1, 32'd27, 5);
    do_op(3'd0, 32'd6, 32'd7, 5'd0, 1'b1, 32'd42, 0);
    do_op(3'd5, 32'd100, 32'd7, 5'd12, 1'b1, 32'd14, 34);

    for (int i = 0; i < 50 && bus.busy; i++) @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = 3'd4;
    bus.rs1_val = 32'd1000;
    bus.rs2_val = 32'd3;
    bus.rd_in   = 5'd13;
    @(negedge clk);
    c0        = cyc;
    bus.start = 1'b0;
    for (int i = 0; i < 20 && cyc < c0 + 9; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.wb_en) seen = 1'b1;
    end
    check("rst_mid_no_done", 32'(seen), 32'd0);
    do_op(3'd4, 32'd1000, 32'd3, 5'd13, 1'b1, 32'd333, 0);

    for (int n = 0; n < 120; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      int          mode, extra;
      op   = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      mode = $urandom_range(0, 9);
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) b = 32'($urandom_range(1, 15));
      else if (mode == 3) a = 32'($urandom_range(0, 15));
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 34) : 0;
      do_op(op, a, b, rd, 1'b0, 32'd0, extra);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the two register-file read operands (RD1/RD2 values) and the destination index.
- Produces a result plus a one-cycle write-enable destined for the register file write port (WD3/A3/WE3).
- The core stalls on busy; the unit runs 32 iterations with a start/busy/done handshake.

Parameters:
- DATA_WIDTH, 32, operand and result width; iteration count equals DATA_WIDTH.
- ADDRESS_WIDTH, 5, destination register index width.

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val  input  DATA_WIDTH  operand A (RD1)
- rs2_val  input  DATA_WIDTH  operand B (RD2)
- rd_in  input  ADDRESS_WIDTH  destination register index
- busy  output  1  high from acceptance edge until done cycle ends
- done  output  1  one-cycle completion pulse
- result  output  DATA_WIDTH  result; held until next accepted start
- rd_out  output  ADDRESS_WIDTH  latched destination index
- wb_en  output  1  write enable to register file; equals done AND (rd_out != 0)

Behaviour:
- Reset values: busy=0, done=0, wb_en=0, result=0, rd_out=0, state=IDLE, counter=0.
- Reset asserted mid-operation aborts the operation: state returns to IDLE with all reset values, and no done/wb_en is issued.
- States:
  - IDLE: on start=1 at edge E0, latch op and rd_in. Latch |A| and |B| per signedness: MULH/DIV/REM treat both operands as signed; MULHSU treats only A as signed; others unsigned. Record the result sign and any special-case flags. Go to CALC; busy=1.
  - CALC: one iteration per edge, E1..E32.
    - Multiply: shift-add into a 2*DATA_WIDTH accumulator.
    - Divide: restoring division, one quotient bit per edge.
    - After E32, go to FIN.
  - FIN: at E33, apply sign correction (two's-complement negate). Select the low word for MUL, the high word for MULH*, the quotient for DIV*, the remainder for REM*. Register result, set done=1, set wb_en per rule. Go to DONE.
  - DONE: lasts one cycle. At E34: done=0, wb_en=0, busy=0, go to IDLE.
- Latency: start at E0 → done high between E33 and E34.
- start while busy=1 (including the DONE cycle) is ignored. Operands are not re-sampled.
- Signs:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the dividend's sign.
  - Product sign is the XOR of signed-operand signs.
- Divide by zero: DIV/DIVU → all ones; REM/REMU → dividend unchanged.
- Signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- Special cases are flagged at E0. The result is forced at FIN, and latency is unchanged unless the optional feature is enabled.
- rd_in=0: full operation runs, done pulses, wb_en stays 0.
- result and rd_out are stable from E33 until the next accepted start's FIN.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: divide-by-zero and signed-overflow cases skip CALC. At E1 the state goes to FIN, so done is high from E2 to E3; busy falls at E3. Normal operations keep the 33-edge latency.
- Undefined: every operation, including special cases, has a fixed done at E33.

Test Plan:
- MUL A=7, B=0xFFFFFFFD, rd_in=5, start at E0 → busy=1 from E0; done=1, wb_en=1, result=0xFFFFFFEB, rd_out=5 exactly at E33; busy=0 after E34.
- MULH A=B=0x80000000 → result 0x40000000.
- MULHU A=B=0xFFFFFFFF → result 0xFFFFFFFE.
- MULHSU A=0xFFFFFFFF, B=2 → result 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 → result 0xFFFFFFFD. REM with the same operands → result 0xFFFFFFFF.
- DIVU A=5, B=0 → result 0xFFFFFFFF. REMU A=5, B=0 → result 5. DIV A=0x80000000, B=0xFFFFFFFF → result 0x80000000. REM with the same operands → result 0.
  - Done timing is E33 without MULDIV_EARLY_OUT_EN, E2 with it.
- Protocol checks:
  - Second start pulse at E5 with different operands → ignored; the first result is intact at E33.
  - rd_in=0 → done pulses, wb_en=0.
  - rst=1 at E10 → busy=0 at E11; no done ever.
  - A new start after reset completes normally.
